// File: rtl/vp_value_table_if.sv
// Lookup/train/flush bundle between the load pipeline and the last-value prediction table.
// The table (slave) accepts a lookup or train only in a cycle where ready=1; results come back one cycle later.
interface vp_value_table_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  lookup_en;
    logic [ADDR_WIDTH-1:0] lookup_pc;
    logic                  train_en;
    logic [ADDR_WIDTH-1:0] train_pc;
    logic [DATA_WIDTH-1:0] train_value;
    logic                  flush;
    logic                  ready;
    logic                  lookup_valid;
    logic                  lookup_hit;
    logic [DATA_WIDTH-1:0] pred_value;
    logic                  pred_confident;
    logic                  dbg_state;

    modport master (
        output lookup_en, lookup_pc, train_en, train_pc, train_value, flush,
        input  ready, lookup_valid, lookup_hit, pred_value, pred_confident, dbg_state
    );

    modport slave (
        input  lookup_en, lookup_pc, train_en, train_pc, train_value, flush,
        output ready, lookup_valid, lookup_hit, pred_value, pred_confident, dbg_state
    );
endinterface

// File: rtl/vp_value_table.sv
// Direct-mapped, tagged last-value prediction table with saturating confidence
// counters and a one-entry-per-cycle flush sweep.
module vp_value_table #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    vp_value_table_if.slave    bus
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_WIDTH - 2;
    localparam logic [CONF_BITS-1:0]   CONF_MAX = '1;
    localparam logic [CONF_BITS-1:0]   THRESH   = CONF_BITS'(CONF_THRESH);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [INDEX_WIDTH-1:0] r_flush_idx;

    logic                   r_valid [ENTRIES];
    logic [TAG_W-1:0]       r_tag   [ENTRIES];
    logic [DATA_WIDTH-1:0]  r_value [ENTRIES];
    logic [CONF_BITS-1:0]   r_conf  [ENTRIES];

    logic                   r_lookup_valid;
    logic                   r_lookup_hit;
    logic [DATA_WIDTH-1:0]  r_pred_value;
    logic                   r_pred_confident;

    logic                   w_idle, w_accept, w_do_lookup, w_do_train;
    logic [INDEX_WIDTH-1:0] w_lk_idx, w_tr_idx;
    logic [TAG_W-1:0]       w_lk_tag, w_tr_tag;
    logic                   w_lk_hit, w_tr_hit, w_tr_same;
    logic                   w_unused_pc_bits;

    // A flush in the same cycle as a request takes priority and drops the request.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = w_idle && !bus.flush;
    assign w_do_lookup = w_accept && bus.lookup_en;
    assign w_do_train  = w_accept && bus.train_en;

    assign w_lk_idx  = bus.lookup_pc[INDEX_WIDTH+1:2];
    assign w_lk_tag  = bus.lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign w_tr_idx  = bus.train_pc[INDEX_WIDTH+1:2];
    assign w_tr_tag  = bus.train_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_tr_hit  = r_valid[w_tr_idx] && (r_tag[w_tr_idx] == w_tr_tag);
    assign w_tr_same = w_tr_hit && (r_value[w_tr_idx] == bus.train_value);
    assign w_unused_pc_bits = ^{bus.lookup_pc[1:0], bus.train_pc[1:0]};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.flush) w_state_next = ST_FLUSH;
            ST_FLUSH: if (!bus.flush && r_flush_idx == LAST_IDX) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)                   r_flush_idx <= '0;
        else if (bus.flush)          r_flush_idx <= '0;
        else if (r_state == ST_FLUSH) r_flush_idx <= r_flush_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_conf[i]  <= '0;
            end
        end else if (r_state == ST_FLUSH) begin
            r_valid[r_flush_idx] <= 1'b0;
            r_conf[r_flush_idx]  <= '0;
        end else if (w_do_train) begin
            if (w_tr_same) begin
                if (r_conf[w_tr_idx] != CONF_MAX) r_conf[w_tr_idx] <= r_conf[w_tr_idx] + 1'b1;
            end else begin
                r_valid[w_tr_idx] <= 1'b1;
                r_conf[w_tr_idx]  <= '0;
            end
        end
    end

    // Payload needs no reset: it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        if (w_do_train && !w_tr_same) begin
            r_tag[w_tr_idx]   <= w_tr_tag;
            r_value[w_tr_idx] <= bus.train_value;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_lookup_valid   <= 1'b0;
            r_lookup_hit     <= 1'b0;
            r_pred_value     <= '0;
            r_pred_confident <= 1'b0;
        end else begin
            r_lookup_valid <= w_do_lookup;
            if (w_do_lookup) begin
                r_lookup_hit     <= w_lk_hit;
                r_pred_value     <= w_lk_hit ? r_value[w_lk_idx] : '0;
                r_pred_confident <= w_lk_hit && (r_conf[w_lk_idx] >= THRESH);
            end
        end
    end

    assign bus.ready          = w_idle;
    assign bus.lookup_valid   = r_lookup_valid;
    assign bus.lookup_hit     = r_lookup_hit;
    assign bus.pred_value     = r_pred_value;
    assign bus.pred_confident = r_pred_confident;
    assign bus.dbg_state      = r_state;
endmodule

// File: doc/vp_value_table.md
# vp_value_table

Last-value prediction table that supplies the value predictor with a per-PC predicted load value and a confidence flag. It sits directly upstream of the value-prediction/recovery stage: a lookup is issued at the load's address-generation point, and training is issued when the real D-cache data returns. The table is direct-mapped, tagged, and carries saturating confidence counters. A sequential flush sweep clears it after a pipeline-wide invalidate.

## Interface
- INDEX_WIDTH, 6: table has 2^INDEX_WIDTH entries; index = pc[INDEX_WIDTH+1:2].
- CONF_BITS, 2: width of the per-entry saturating confidence counter.
- CONF_THRESH, 2: counter value at or above which pred_confident asserts.
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous reset, active-high despite the suffix.
- lookup_en  in  1  lookup request, sampled when ready=1.
- lookup_pc  in  ADDR_WIDTH  load PC for the lookup.
- train_en  in  1  training request, sampled when ready=1.
- train_pc  in  ADDR_WIDTH  PC of the resolved load.
- train_value  in  DATA_WIDTH  actual loaded data.
- flush  in  1  start full-table invalidate sweep (single-cycle pulse).
- ready  out  1  table accepts lookup/train this cycle.
- lookup_valid  out  1  lookup result is present this cycle (one-cycle pulse).
- lookup_hit  out  1  entry valid and tag match.
- pred_value  out  DATA_WIDTH  stored last value; 0 on a miss.
- pred_confident  out  1  hit and counter >= CONF_THRESH.

## Operation
- Entry fields: valid, tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2], value[DATA_WIDTH], conf[CONF_BITS].
- FSM states:
  - IDLE: ready=1.
  - FLUSH: ready=0. A counter sweeps index 0..2^INDEX_WIDTH-1, clearing valid and conf of one entry per cycle. After the last index it returns to IDLE.
- IDLE->FLUSH on flush=1. Any flush during FLUSH restarts the counter at 0.
- Lookup (IDLE, lookup_en=1): read entry, compare tag, register the result. Miss forces pred_value=0, lookup_hit=0, pred_confident=0.
- Train (IDLE, train_en=1), single-cycle read-modify-write:
  - Tag match, valid, value equal: conf saturating increment; max value is 2^CONF_BITS-1.
  - Tag match, valid, value differs: value <= train_value, conf <= 0.
  - Miss or invalid: allocate (replace). valid=1, tag, value=train_value, conf=0.
- Simultaneous lookup and train to the same index in one cycle: the lookup returns pre-train contents.
- Simultaneous lookup and train to different indices: both complete independently.
- flush and train/lookup in the same IDLE cycle: flush wins; the train is dropped and lookup_valid stays 0 next cycle.
- lookup_en/train_en while ready=0: ignored, no state change, no lookup_valid.
- Reset: FSM=IDLE, counter=0, all valid=0, all conf=0. Outputs: ready=1, lookup_valid=0, lookup_hit=0, pred_value=0, pred_confident=0.
- Reset asserted mid-flush: aborts to IDLE with the whole table invalid.

## Timing
- Lookup latency 1: request at cycle N, result outputs valid during N+1 only. Outputs hold their values, but lookup_valid drops at N+2 unless a new lookup is issued.
- Train visibility: a train at N is visible to a lookup issued at N+1 or later.
- Flush duration: pulse at N -> ready=0 during N+1 .. N+2^INDEX_WIDTH. ready=1 at N+2^INDEX_WIDTH+1, which is 64 cycles of busy at default.
- Back-to-back lookups every cycle are supported, giving one result per cycle.
- Counter saturation: conf never wraps. At 3 with CONF_BITS=2, further matches hold 3.

## Test plan
- Reset, then lookup pc=0x0040_0010 -> next cycle lookup_valid=1, hit=0, pred_value=0, pred_confident=0.
- Train pc=0x0040_0010 with value 0xDEAD_BEEF three times, then lookup -> hit=1, pred_value=0xDEAD_BEEF, conf=2, pred_confident=1. A fourth and fifth matching train leaves conf saturated at 3.
- Aliasing: train pc=0x0040_0010, then train pc=0x0040_0110 (same index, different tag), then lookup 0x0040_0010 -> hit=0, pred_value=0. Lookup 0x0040_0110 -> hit=1, conf=0.
- Mismatch: confident entry holding 0x5, train with 0x6 -> lookup returns 0x6, pred_confident=0.
- Same cycle, same index: lookup and train (0x7 into an entry holding 0x5) issued together -> result shows 0x5. A lookup issued on the next cycle shows 0x7.
- Flush: populate 4 entries, pulse flush -> ready=0 for exactly 64 cycles, lookup/train ignored meanwhile. Afterwards all four lookups miss. Assert reset at flush cycle 20 -> ready=1 immediately and all entries miss.
